// File: rtl/ad_capture_sched_if.sv
// Capture scheduler bus: frame control, sync pulses, configuration, FIFO
// write strobe and status. clk/reset_n stay outside as plain ports.
//
// Signalling: start_i is a one-cycle request that is taken only while
// busy_o is low; busy_o rises the cycle after it is taken. sample_en_o is a
// one-cycle write strobe with no ready/valid return path. fifo_full_i is
// sampled on the same clock edge that registers sample_en_o. When it is high,
// the strobe for that sample is dropped, overflow_o is set and the sample
// slot is still used.
interface ad_capture_sched_if #(
  parameter int DLY_W  = 32,
  parameter int NUM_W  = 16,
  parameter int LINE_W = 12
);
  logic              start_i;
  logic              abort_i;
  logic              hsync_redge_i;
  logic              vsync_redge_i;
  logic [LINE_W-1:0] line_start_i;
  logic [LINE_W-1:0] line_count_i;
  logic [DLY_W-1:0]  delay_count_i;
  logic [NUM_W-1:0]  sample_num_i;
  logic [4:0]        decim_i;
  logic              fifo_full_i;
  logic              sample_en_o;
  logic [LINE_W-1:0] line_idx_o;
  logic              busy_o;
  logic              frame_done_o;
  logic              overflow_o;
  logic              err_short_o;
  logic              err_frame_o;
  logic [2:0]        dbg_state;

  modport master (
    output start_i, abort_i, hsync_redge_i, vsync_redge_i, line_start_i,
           line_count_i, delay_count_i, sample_num_i, decim_i, fifo_full_i,
    input  sample_en_o, line_idx_o, busy_o, frame_done_o, overflow_o,
           err_short_o, err_frame_o, dbg_state
  );

  modport slave (
    input  start_i, abort_i, hsync_redge_i, vsync_redge_i, line_start_i,
           line_count_i, delay_count_i, sample_num_i, decim_i, fifo_full_i,
    output sample_en_o, line_idx_o, busy_o, frame_done_o, overflow_o,
           err_short_o, err_frame_o, dbg_state
  );
endinterface

// File: rtl/ad_capture_sched.sv
// ADC frame capture scheduler: waits for vsync, skips to the first wanted
// line, delays from each hsync and emits decimated FIFO write strobes.
module ad_capture_sched #(
  parameter int DLY_W  = 32,
  parameter int NUM_W  = 16,
  parameter int LINE_W = 12
) (
  input logic               clk,
  input logic               reset_n,
  ad_capture_sched_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WAIT_HS = 3'd2,
    DELAY   = 3'd3,
    SAMPLE  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  logic [LINE_W-1:0] sh_line_start;
  logic [LINE_W-1:0] sh_line_count;
  logic [DLY_W-1:0]  sh_delay;
  logic [NUM_W-1:0]  sh_num;
  logic [4:0]        sh_decim;
  logic [LINE_W-1:0] raw_cnt;
  logic [LINE_W-1:0] cap_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [NUM_W-1:0]  samp_cnt;
  logic [4:0]        dec_cnt;

  logic              hs;
  logic              vs;
  logic              in_line;
  logic              hs_short;
  logic              short_end;
  logic              skip_line;
  logic              line_begin;
  logic              fire;
  logic              last_samp;
  logic              frame_end;
  logic [LINE_W-1:0] raw_cur;
  logic [LINE_W-1:0] cap_cur;
  logic [NUM_W-1:0]  samp_base;

  // The raw line counter saturates, so it never wraps inside a frame.
  function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + LINE_W'(1);
  endfunction

  assign hs            = bus.hsync_redge_i;
  assign vs            = bus.vsync_redge_i;
  assign bus.dbg_state = state;

  // Per-edge event decode. vsync has priority over hsync. A short line is
  // counted before any sample that a new line start fires on the same edge.
  always_comb begin
    in_line    = (state == DELAY) || (state == SAMPLE);
    hs_short   = in_line && hs && !vs;
    raw_cur    = hs_short ? sat_inc(raw_cnt) : raw_cnt;
    cap_cur    = hs_short ? cap_cnt + LINE_W'(1) : cap_cnt;
    short_end  = hs_short && (cap_cur == sh_line_count);
    skip_line  = (state == WAIT_HS) && hs && !vs && (raw_cnt < sh_line_start);
    line_begin = ((state == WAIT_HS) && hs && !vs && !(raw_cnt < sh_line_start)) ||
                 (hs_short && !short_end);
    samp_base  = line_begin ? '0 : samp_cnt;
    fire       = (line_begin && (sh_delay == '0)) ||
                 ((state == DELAY) && !hs && !vs && (dly_cnt == DLY_W'(1))) ||
                 ((state == SAMPLE) && !hs && !vs && (dec_cnt == 5'd0));
    last_samp  = (samp_base + NUM_W'(1)) == sh_num;
    frame_end  = (cap_cur + LINE_W'(1)) == sh_line_count;
  end

  // Scheduler FSM with registered outputs. abort_i overrides every other event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      sh_line_start    <= '0;
      sh_line_count    <= '0;
      sh_delay         <= '0;
      sh_num           <= '0;
      sh_decim         <= '0;
      raw_cnt          <= '0;
      cap_cnt          <= '0;
      dly_cnt          <= '0;
      samp_cnt         <= '0;
      dec_cnt          <= '0;
      bus.sample_en_o  <= 1'b0;
      bus.line_idx_o   <= '0;
      bus.busy_o       <= 1'b0;
      bus.frame_done_o <= 1'b0;
      bus.overflow_o   <= 1'b0;
      bus.err_short_o  <= 1'b0;
      bus.err_frame_o  <= 1'b0;
    end else begin
      bus.sample_en_o  <= 1'b0;
      bus.frame_done_o <= 1'b0;
      if (bus.abort_i) begin
        state      <= IDLE;
        bus.busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i) begin
              sh_line_start   <= bus.line_start_i;
              sh_line_count   <= bus.line_count_i;
              sh_delay        <= bus.delay_count_i;
              sh_num          <= bus.sample_num_i;
              sh_decim        <= bus.decim_i;
              bus.overflow_o  <= 1'b0;
              bus.err_short_o <= 1'b0;
              bus.err_frame_o <= 1'b0;
              bus.busy_o      <= 1'b1;
              if ((bus.line_count_i == '0) || (bus.sample_num_i == '0)) begin
                state <= DONE;
              end else begin
                state <= WAIT_VS;
              end
            end
          end
          WAIT_VS: begin
            if (vs) begin
              raw_cnt <= '0;
              cap_cnt <= '0;
              state   <= WAIT_HS;
            end
          end
          DONE: begin
            bus.frame_done_o <= 1'b1;
            bus.busy_o       <= 1'b0;
            state            <= IDLE;
          end
          default: begin
            if (vs) begin
              bus.err_frame_o <= 1'b1;
              state           <= DONE;
            end else begin
              if (hs_short) begin
                bus.err_short_o <= 1'b1;
                raw_cnt         <= raw_cur;
                cap_cnt         <= cap_cur;
              end
              if (short_end) begin
                state <= DONE;
              end else if (skip_line) begin
                raw_cnt <= sat_inc(raw_cnt);
              end else if (line_begin && !fire) begin
                state    <= DELAY;
                dly_cnt  <= sh_delay;
                samp_cnt <= '0;
              end else if ((state == DELAY) && !fire) begin
                dly_cnt <= dly_cnt - DLY_W'(1);
              end else if ((state == SAMPLE) && !fire) begin
                dec_cnt <= dec_cnt - 5'd1;
              end
              if (fire) begin
                bus.sample_en_o <= !bus.fifo_full_i;
                bus.line_idx_o  <= cap_cur;
                if (bus.fifo_full_i) begin
                  bus.overflow_o <= 1'b1;
                end
                if (last_samp) begin
                  samp_cnt <= '0;
                  raw_cnt  <= sat_inc(raw_cur);
                  cap_cnt  <= cap_cur + LINE_W'(1);
                  state    <= frame_end ? DONE : WAIT_HS;
                end else begin
                  samp_cnt <= samp_base + NUM_W'(1);
                  dec_cnt  <= sh_decim;
                  state    <= SAMPLE;
                end
              end
            end
          end
        endcase
      end
    end
  end
endmodule
